// File: rtl/rf_pkg.sv
// Shared constants and packed-port helpers for the register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned RF_DEPTH  = 16;
  localparam int unsigned RF_CNT_W  = 2;

  function automatic int unsigned lsb(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight counters, issue stall and sticky underflow error.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_dest_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  output logic              issue_stall_o,
  output logic              sb_err_o,
  output logic [DEPTH-1:0]  pend_o,
  output logic [DEPTH-1:0]  last_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic             err_q, err_d;
  logic             full_hit, inc;
  logic             is_hit, wb_hit;

  always_comb begin
    full_hit = 1'b0;
    for (int r = 0; r < DEPTH; r++)
      if (issue_dest_i == ADDR_W'(r) && cnt_q[r] == MAX)
        full_hit = 1'b1;
  end

  // A landing write-back to the same register frees the slot this cycle
  assign issue_stall_o = issue_en_i && full_hit &&
                         !(wb_en_i && wb_addr_i == issue_dest_i);
  assign inc = issue_en_i && !issue_stall_o;

  always_comb begin
    cnt_d  = cnt_q;
    err_d  = err_q;
    is_hit = 1'b0;
    wb_hit = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      is_hit = inc && issue_dest_i == ADDR_W'(r);
      wb_hit = wb_en_i && wb_addr_i == ADDR_W'(r);
      if (is_hit && !wb_hit)
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (wb_hit && !is_hit) begin
        if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - 1'b1;
        else
          err_d = 1'b1;
      end
    end
  end

  always_comb begin
    pend_o = '0;
    last_o = '0;
    for (int r = 0; r < DEPTH; r++) begin
      pend_o[r] = cnt_q[r] != '0;
      last_o[r] = cnt_q[r] == CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign sb_err_o = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with combinational reads and in-flight scoreboard.
// Optional write-through forwarding: define RF_BYPASS_EN.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_hazard,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic                     issue_stall,
  output logic                     sb_err
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  last;
  logic [ADDR_W-1:0] a;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .issue_en_i    (issue_en),
    .issue_dest_i  (issue_dest),
    .wb_en_i       (wb_en),
    .wb_addr_i     (wb_addr),
    .issue_stall_o (issue_stall),
    .sb_err_o      (sb_err),
    .pend_o        (pend),
    .last_o        (last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      data_q <= '{default: '0};
    else
      for (int r = 0; r < DEPTH; r++)
        if (wb_en && wb_addr == ADDR_W'(r))
          data_q[r] <= wb_data;
  end

`ifdef RF_BYPASS_EN
  logic wb_fwd;

  always_comb begin
    rd_data   = '0;
    rd_hazard = '0;
    a         = '0;
    wb_fwd    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      a      = rd_addr[lsb(i, ADDR_W) +: ADDR_W];
      wb_fwd = wb_en && wb_addr == a;
      for (int r = 0; r < DEPTH; r++)
        if (a == ADDR_W'(r)) begin
          rd_data[lsb(i, DATA_W) +: DATA_W] =
            wb_fwd ? wb_data : data_q[r];
          rd_hazard[i] = pend[r] && !(wb_fwd && last[r]);
        end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    rd_data   = '0;
    rd_hazard = '0;
    a         = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[lsb(i, ADDR_W) +: ADDR_W];
      for (int r = 0; r < DEPTH; r++)
        if (a == ADDR_W'(r)) begin
          rd_data[lsb(i, DATA_W) +: DATA_W] = data_q[r];
          rd_hazard[i] = pend[r];
        end
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Vector-table bench for reg_file_sb with an expected-result queue.
module tb_reg_file_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        wbe;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic        ie;
    logic [3:0]  id;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  h;
    logic        st;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_hazard;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        issue_stall;
  logic        sb_err;

  int checks   = 0;
  int failures = 0;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t v, e;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_hazard   (rd_hazard),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .issue_en    (issue_en),
    .issue_dest  (issue_dest),
    .issue_stall (issue_stall),
    .sb_err      (sb_err)
  );

  function automatic vec_t mk(
    input logic        rs,
    input logic        we,
    input logic [3:0]  wa,
    input logic [31:0] wd,
    input logic        ie,
    input logic [3:0]  id,
    input logic [3:0]  r0,
    input logic [3:0]  r1,
    input logic [31:0] d0,
    input logic [31:0] d1,
    input logic [1:0]  h,
    input logic        st,
    input logic        er
  );
    vec_t t;
    t.rst = rs; t.wbe = we; t.wba = wa; t.wbd = wd;
    t.ie = ie; t.id = id; t.r0 = r0; t.r1 = r1;
    t.d0 = d0; t.d1 = d1; t.h = h; t.st = st; t.err = er;
    return t;
  endfunction

  task automatic chk(
    input int          k,
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL vec%0d %s got=%h want=%h", k, nm, act, want);
    end
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    issue_en = 1'b0; issue_dest = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state, then write r3 and reset over it
    tbl.push_back(mk(0,0,0,0,0,0,3,5, 0,0,2'b00,0,0));
    tbl.push_back(mk(0,1,3,32'hDEAD,0,0,3,0,
                     BYP ? 32'hDEAD : 0,0,2'b00,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,3,3, 32'hDEAD,32'hDEAD,2'b00,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,3,3, 0,0,2'b00,0,0));
    // basic write/read on r5
    tbl.push_back(mk(0,0,0,0,1,5,5,0, 0,0,2'b00,0,0));
    tbl.push_back(mk(0,1,5,32'h12345678,0,0,5,5,
                     BYP ? 32'h12345678 : 0,
                     BYP ? 32'h12345678 : 0,
                     BYP ? 2'b00 : 2'b11,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,5,5,
                     32'h12345678,32'h12345678,2'b00,0,0));
    // two producers on r2
    tbl.push_back(mk(0,0,0,0,1,2,2,5, 0,32'h12345678,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,1,2,2,2, 0,0,2'b11,0,0));
    tbl.push_back(mk(0,1,2,32'hAAAA,0,0,2,0,
                     BYP ? 32'hAAAA : 0,0,2'b01,0,0));
    tbl.push_back(mk(0,1,2,32'hBBBB,0,0,2,2,
                     BYP ? 32'hBBBB : 32'hAAAA,
                     BYP ? 32'hBBBB : 32'hAAAA,
                     BYP ? 2'b00 : 2'b11,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,2,2, 32'hBBBB,32'hBBBB,2'b00,0,0));
    // saturate r7
    tbl.push_back(mk(0,0,0,0,1,7,7,0, 0,0,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,1,7,7,0, 0,0,2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,1,7,7,0, 0,0,2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,1,7,7,7, 0,0,2'b11,1,0));
    tbl.push_back(mk(0,1,7,32'h7777,1,7,7,0,
                     BYP ? 32'h7777 : 0,0,2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,1,7,7,0, 32'h7777,0,2'b01,1,0));
    tbl.push_back(mk(0,1,7,32'h7777,0,0,7,0, 32'h7777,0,2'b01,0,0));
    tbl.push_back(mk(0,1,7,32'h7777,0,0,7,0, 32'h7777,0,2'b01,0,0));
    tbl.push_back(mk(0,1,7,32'h7777,0,0,7,0,
                     32'h7777,0,BYP ? 2'b00 : 2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,7,0, 32'h7777,0,2'b00,0,0));
    // underflow: simultaneous issue+wb is fine, lone wb is not
    tbl.push_back(mk(0,1,9,32'h9999,1,9,9,0,
                     BYP ? 32'h9999 : 0,0,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,9,0, 32'h9999,0,2'b00,0,0));
    tbl.push_back(mk(0,1,9,32'h1,0,0,9,0,
                     BYP ? 32'h1 : 32'h9999,0,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,9,0, 32'h1,0,2'b00,0,1));
    tbl.push_back(mk(0,0,0,0,1,9,9,0, 32'h1,0,2'b00,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,9,0, 32'h1,0,2'b01,0,1));
    // reset mid-flight with a concurrent write-back
    tbl.push_back(mk(0,0,0,0,1,4,4,0, 0,0,2'b00,0,1));
    tbl.push_back(mk(0,0,0,0,1,4,4,0, 0,0,2'b01,0,1));
    tbl.push_back(mk(1,1,4,32'h55,0,0,4,9,
                     BYP ? 32'h55 : 0,32'h1,2'b11,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,4,9, 0,0,2'b00,0,0));
    // issue and write-back on different registers
    tbl.push_back(mk(0,1,4,32'h44,1,1,1,4,
                     0,BYP ? 32'h44 : 0,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,4, 0,32'h44,2'b01,0,1));

    foreach (tbl[k]) begin
      v = tbl[k];
      @(negedge clk);
      rst        = v.rst;
      wb_en      = v.wbe;
      wb_addr    = v.wba;
      wb_data    = v.wbd;
      issue_en   = v.ie;
      issue_dest = v.id;
      rd_addr    = {v.r1, v.r0};
      exp_q.push_back(v);
      #2;
      e = exp_q.pop_front();
      chk(k, "rd_data0",  rd_data[31:0],        e.d0);
      chk(k, "rd_data1",  rd_data[63:32],       e.d1);
      chk(k, "rd_hazard", {30'b0, rd_hazard},   {30'b0, e.h});
      chk(k, "stall",     {31'b0, issue_stall}, {31'b0, e.st});
      chk(k, "sb_err",    {31'b0, sb_err},      {31'b0, e.err});
    end

    @(negedge clk);
    rst = 1'b0; wb_en = 1'b0; issue_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the ARM pipeline: NUM_RD combinational read ports, one write-back port, and an integrated per-register in-flight scoreboard.
- Sits between ID and WB. ID reads operands and gets a per-port hazard flag. ID marks a destination as pending at issue. WB commits results and clears pending.
- Writes on the rising edge. Same-cycle visibility comes from an optional bypass.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width
- DEPTH, 16, number of registers; must be ≤ 2**ADDR_W
- NUM_RD, 2, number of read ports
- CNT_W, 2, width of the per-register in-flight counter; max outstanding writes per register = 2**CNT_W-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- rd_hazard  out  NUM_RD  bit i high when the register read by port i still has an uncommitted producer
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back value
- issue_en  in  1  an instruction with a destination register issues this cycle
- issue_dest  in  ADDR_W  destination of the issuing instruction
- issue_stall  out  1  combinational; issue_en would overflow the counter of issue_dest
- sb_err  out  1  sticky; a write-back arrived for a register whose counter was 0

Behaviour:
- Reset:
  - rst sampled high clears all data entries to 0, all counters to 0 and sb_err to 0.
  - rst overrides any concurrent wb_en or issue_en.
  - Asserting rst mid-operation discards all in-flight state.
- Reads:
  - Purely combinational, zero latency.
  - rd_data[i] = data[rd_addr[i]].
  - Any address ≥ DEPTH reads 0 with hazard 0.
- Write:
  - On posedge, if wb_en and wb_addr < DEPTH, then data[wb_addr] <= wb_data.
  - Out-of-range writes are dropped.
- Counter update per posedge (inc = issue_en && !issue_stall && issue_dest < DEPTH; dec = wb_en && wb_addr < DEPTH):
  - inc only: cnt[issue_dest] + 1.
  - dec only: cnt[wb_addr] - 1 when nonzero. When zero, the counter holds at 0 and sb_err is set.
  - inc and dec on the same register: counter unchanged; a dec from 0 in this case is not an error.
  - inc and dec on different registers: both apply independently.
- issue_stall = issue_en && cnt[issue_dest] == 2**CNT_W-1 && !(wb_en && wb_addr == issue_dest). An issue that is stalled does not increment.
- rd_hazard[i] = cnt[a] != 0 && !(wb_en && wb_addr == a && cnt[a] == 1), where a = rd_addr[i]. The last outstanding write-back landing this cycle resolves the hazard only when bypass is compiled in; without bypass the second term is omitted.
- Multiple read ports on the same address return identical data and hazard.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - When wb_en and wb_addr == rd_addr[i] (in range), rd_data[i] = wb_data combinationally (write-through forwarding).
  - The resolving term in rd_hazard is active.
- Undefined:
  - rd_data shows the pre-write value until the next cycle.
  - rd_hazard stays high in the write-back cycle.

Decomposition:
- Shared package rf_pkg holds the default DATA_W, ADDR_W, DEPTH and CNT_W constants, plus the bit-range helper for packed port indexing.
- One sub-module, rf_scoreboard, holds the counter array, issue_stall, sb_err, and the raw pending vector.
- The top level holds the data array, read muxing and bypass.

Test Plan:
- Reset: write r3=0xDEAD, then assert rst for 1 cycle -> all rd_data = 0, rd_hazard = 0, sb_err = 0.
- Basic write/read: wb r5=0x12345678 -> the next cycle rd_addr0=5 returns 0x12345678. With RF_BYPASS_EN the value appears in the same cycle; without it the old value 0 shows in that cycle.
- Scoreboard:
  - Issue r2 twice (cnt=2) -> rd_hazard on r2 = 1.
  - First wb r2 -> still 1.
  - Second wb r2 -> 0 the following cycle, or in the same cycle with bypass.
- Saturation:
  - Issue r7 three times (CNT_W=2) -> a fourth issue_en to r7 gives issue_stall=1 and cnt stays 3.
  - Same cycle with wb_en r7 -> issue_stall=0, cnt stays 3.
- Error: wb r9 with cnt=0 -> sb_err=1 and stays 1 until rst. Simultaneous issue+wb to r9 at cnt=0 -> no error, cnt=0.
- Reset mid-flight: cnt[4]=2 with wb_en r4=0x55 in the same cycle as rst -> after reset data[4]=0, cnt=0, no hazard.
